gpio_input_filter: RTL

GPIO_INPUT_FILTER -- requirements
Module: gpio_input_filter

---
 rtl/gpio_pkg.sv | 8 +
 rtl/gpio_filter_cell.sv | 85 ++++++++
 rtl/gpio_input_filter.sv | 61 ++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared defaults for the GPIO input conditioning path.
package gpio_pkg;

   localparam int unsigned NUM_PINS_DEF = 32;
   localparam int unsigned PRESC_W_DEF  = 16;
   localparam int unsigned THR_W_DEF    = 8;

endpackage

// File: rtl/gpio_filter_cell.sv
// Per-pin conditioning: 2-flop synchronizer, stability counter, filtered
// level and registered edge pulses.
module gpio_filter_cell
   import gpio_pkg::*;
#(
   parameter int unsigned THR_W = THR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pin_raw,
   input  logic             filter_en,
   input  logic             tick,
   input  logic [THR_W-1:0] threshold,
   output logic             pin_filtered,
   output logic             rise_pulse,
   output logic             fall_pulse
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             prev_q,  prev_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;
   logic [THR_W-1:0] cnt_q,   cnt_d;

   logic [THR_W:0]   inc_full;
   logic [THR_W-1:0] inc_sat;
   logic [THR_W-1:0] thr_eff;

   // Next-state: synchronizer, bypass/debounce level, saturating counter, pulses.
   always_comb begin
      sync1_d  = pin_raw;
      sync2_d  = sync1_q;
      prev_d   = level_q;
      rise_d   = level_q & ~prev_q;
      fall_d   = ~level_q & prev_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      inc_full = {1'b0, cnt_q} + (THR_W+1)'(1);
      inc_sat  = inc_full[THR_W] ? '1 : inc_full[THR_W-1:0];
      thr_eff  = (threshold == '0) ? THR_W'(1) : threshold;

      if (!filter_en) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (tick) begin
         // >= so a lowered threshold takes effect at the very next tick
         if (inc_sat >= thr_eff) begin
            level_d = ~level_q;
            cnt_d   = '0;
         end else begin
            cnt_d = inc_sat;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         prev_q  <= prev_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pin_filtered = level_q;
   assign rise_pulse   = rise_q;
   assign fall_pulse   = fall_q;

endmodule

// File: rtl/gpio_input_filter.sv
// GPIO input filter: shared sample prescaler plus one conditioning cell per pin.
module gpio_input_filter
   import gpio_pkg::*;
#(
   parameter int unsigned NUM_PINS = NUM_PINS_DEF,
   parameter int unsigned PRESC_W  = PRESC_W_DEF,
   parameter int unsigned THR_W    = THR_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_PINS-1:0] pin_raw,
   input  logic [NUM_PINS-1:0] filter_en,
   input  logic [PRESC_W-1:0]  prescale,
   input  logic [THR_W-1:0]    threshold,
   output logic [NUM_PINS-1:0] pin_filtered,
   output logic [NUM_PINS-1:0] rise_pulse,
   output logic [NUM_PINS-1:0] fall_pulse,
   output logic                sample_tick
);

   logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
   logic               sample_tick_q, sample_tick_d;
   logic               tick;

   // Prescaler: >= makes a prescale drop below the count wrap at once.
   always_comb begin
      tick          = (presc_cnt_q >= prescale);
      presc_cnt_d   = tick ? '0 : presc_cnt_q + PRESC_W'(1);
      sample_tick_d = tick;
   end

   // Prescaler registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_cnt_q   <= '0;
         sample_tick_q <= 1'b0;
      end else begin
         presc_cnt_q   <= presc_cnt_d;
         sample_tick_q <= sample_tick_d;
      end
   end

   assign sample_tick = sample_tick_q;

   for (genvar i = 0; i < NUM_PINS; i++) begin : g_cell
      gpio_filter_cell #(
         .THR_W (THR_W)
      ) u_cell (
         .clk          (clk),
         .rst          (rst),
         .pin_raw      (pin_raw[i]),
         .filter_en    (filter_en[i]),
         .tick         (tick),
         .threshold    (threshold),
         .pin_filtered (pin_filtered[i]),
         .rise_pulse   (rise_pulse[i]),
         .fall_pulse   (fall_pulse[i])
      );
   end

endmodule
